intlatch: RTL and testbench
===========================

# intlatch

Interrupt capture stage sitting directly downstream of the status latches (`stlatch`) in Tom. It takes the held status levels those latches produce and detects rising edges on each of them. Each edge becomes a sticky pending bit, gated by a CPU-writable enable mask. The block drives a single registered active-low interrupt request toward the host CPU, and provides a write-to-clear path for acknowledging sources.

## Interface
- `NSRC`, default 5: number of interrupt sources (VI, GPU, OP, PIT, JERRY); legal range 1..8.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `resetl`  in  1  reset, asynchronous, active-low.
- `src`  in  NSRC  status levels from upstream `stlatch` outputs, synchronous to `sys_clk`.
- `wr`  in  1  control-register write strobe, one cycle per write.
- `din`  in  16  write data:
  - `din[NSRC-1:0]` is the new enable mask.
  - `din[8+NSRC-1:8]` are clear-pending bits; 1 clears the matching pending bit.
- `dout`  out  16  status readback, combinational from registers:
  - `dout[NSRC-1:0]` = pending.
  - `dout[8+NSRC-1:8]` = enable.
  - All other bits 0.
- `intl`  out  1  interrupt request, registered, active-low.

## Operation
- State: `prev[NSRC]` (previous `src` sample), `enable[NSRC]`, `pending[NSRC]`, `intl`.
- Reset (`resetl`=0, asynchronous):
  - `prev` = all ones, so sources already high at reset release do not fire.
  - `enable` = 0, `pending` = 0, `intl` = 1, `dout` = 0.
- Edge detect: `edge[i] = src[i] & ~prev[i]`; `prev <= src` every cycle.
- Pending set: `pending[i]` sets when `edge[i]` and `enable[i]` (current register value, not the value being written this cycle).
  - Edges on disabled sources are discarded, not remembered.
- Pending clear: `wr` and `din[8+i]` clears `pending[i]`.
  - Set and clear in the same cycle: set wins, so no edge is lost.
- Enable write: `wr` loads `enable <= din[NSRC-1:0]`; the new mask is effective from the next cycle.
  - Disabling a source does not clear its pending bit; the bit only stops contributing to `intl`.
- Request: `intl <= ~|(pending & enable)`, using the registered values.
- A second edge on a source already pending: no change; the bit is not a counter.
- `src` held high: exactly one edge; a new edge needs a low sample first.
- Bits of `din` outside the defined fields are ignored.

## Timing
- Source edge sampled at clock k (src=1, prev=0, enable=1): `pending` = 1 after k; `intl` = 0 after k+1. Total latency is 2 clocks.
- Clear write at clock m, with no other enabled pending bits and no new edge: `pending` = 0 after m; `intl` = 1 after m+1.
- Enable write at clock m enabling an already-pending source: `enable` = 1 after m; `intl` = 0 after m+1.
- Enable write at clock m, with an edge on that source at m: edge discarded if the old enable was 0. Edge latched if the old enable was 1, even when the write disables it.
- `dout` reflects register values in the same cycle they update; there is no read side-effect.
- `resetl` asserted mid-operation: all state returns to reset values immediately.
  - First post-reset clock with `src`=1 produces no edge.
  - `src` low then high after reset produces an edge normally.

## Test plan
- Reset with `src`=5'b11111 held high, release, run 4 clocks -> `pending`=0, `intl`=1, `dout`=16'h0000.
- Write `din`=16'h001F, then pulse `src[2]` 0->1 -> `pending` latches after that edge, `dout`=16'h1F04, `intl` low exactly 2 clocks after the sampled edge.
- With `src[2]` pending, write `din`=16'h041F -> `dout`=16'h1F00 next cycle, `intl` high one cycle later. Keep `src[2]` high -> no re-trigger.
- Enable=0, pulse `src[0]`, then write `din`=16'h0001 -> `pending` stays 0, `intl` stays 1 (disabled edge discarded).
- Enable=16'h0001, schedule `src[0]` rising edge in the same cycle as a write `din`=16'h0101 -> `pending[0]`=1 after that clock (set wins), `intl`=0 one clock later.
- Enable all, raise `src[1]` and `src[3]` together, assert `resetl` low for 1 cycle mid-request -> `intl`=1 and `dout`=0 immediately. After release with sources still high, no new pending bits.

Source files
------------

// File: rtl/intlatch.sv
// intlatch: rising-edge interrupt capture with enable mask,
// sticky pending bits, write-to-clear and registered active-low IRQ.
module intlatch #(
  parameter int NSRC = 5
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic [NSRC-1:0] src,
  input  logic            wr,
  input  logic [15:0]     din,
  output logic [15:0]     dout,
  output logic            intl
);

  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic            intl_q, intl_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic            unused_din;

  // Only the mask and clear fields of din are decoded.
  assign unused_din = ^din;

  assign rise = src & ~prev_q;
  assign clr  = wr ? din[8 +: NSRC] : '0;

  // Next-state: edges latch against the old mask; set beats clear.
  always_comb begin
    en_d   = en_q;
    pend_d = pend_q & ~clr;
    pend_d = pend_d | (rise & en_q);
    intl_d = ~|(pend_q & en_q);
    if (wr) begin
      en_d = din[NSRC-1:0];
    end
  end

  // Previous-sample register; ones at reset hide already-high sources.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      prev_q <= '1;
    end else begin
      prev_q <= src;
    end
  end

  // Mask, pending and request registers.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      en_q   <= '0;
      pend_q <= '0;
      intl_q <= 1'b1;
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      intl_q <= intl_d;
    end
  end

  // Readback: pending in the low byte, enable in the high byte.
  always_comb begin
    dout              = '0;
    dout[NSRC-1:0]    = pend_q;
    dout[8 +: NSRC]   = en_q;
  end

  assign intl = intl_q;

endmodule

// File: tb/tb_intlatch.sv
// tb_intlatch: scoreboard bench for intlatch; a bit-level model
// queues expected {dout,intl} per clock, compared after the edge.
module tb_intlatch;

  localparam int N = 5;

  logic         sys_clk = 1'b0;
  logic         resetl;
  logic [N-1:0] src;
  logic         wr;
  logic [15:0]  din;
  logic [15:0]  dout;
  logic         intl;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] sb_q[$];

  logic [N-1:0] m_prev, m_en, m_pend;
  logic         m_intl;

  intlatch #(.NSRC(N)) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .src     (src),
    .wr      (wr),
    .din     (din),
    .dout    (dout),
    .intl    (intl)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [16:0] obs,
                     input logic [16:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_prev = '1;
    m_en   = '0;
    m_pend = '0;
    m_intl = 1'b1;
  endtask

  function automatic logic [16:0] m_out();
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d[i]   = m_pend[i];
      d[8+i] = m_en[i];
    end
    return {d, m_intl};
  endfunction

  // One clock: advance model, push expectation, clock, pop, compare.
  task automatic step(input string tag);
    logic [N-1:0] np, ne;
    logic [16:0]  e;
    logic         any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      np[i] = m_pend[i];
      if (wr && din[8+i]) np[i] = 1'b0;
      if (src[i] && !m_prev[i] && m_en[i]) np[i] = 1'b1;
      ne[i] = wr ? din[i] : m_en[i];
      if (m_pend[i] && m_en[i]) any = 1'b1;
    end
    m_intl = !any;
    m_pend = np;
    m_en   = ne;
    m_prev = src;
    sb_q.push_back(m_out());
    @(posedge sys_clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, {dout, intl}, e);
  endtask

  task automatic wrcyc(input logic [15:0] d, input string tag);
    wr  = 1'b1;
    din = d;
    step(tag);
    wr  = 1'b0;
    din = '0;
  endtask

  initial begin
    resetl = 1'b0;
    src    = 5'b11111;
    wr     = 1'b0;
    din    = '0;
    m_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_state", {dout, intl}, {16'h0000, 1'b1});
    resetl = 1'b1;
    repeat (4) step("rst_hold_hi");
    chk("rst_release", {dout, intl}, {16'h0000, 1'b1});

    // Enable all, pulse src[2].
    wrcyc(16'h001F, "en_all");
    src = 5'b11011;
    step("src2_low");
    src = 5'b11111;
    step("src2_edge");
    chk("pend_lat", {dout, intl}, {16'h1F04, 1'b1});
    step("intl_lat");
    chk("intl_low", {dout, intl}, {16'h1F04, 1'b0});

    // Clear with src[2] still high.
    wrcyc(16'h041F, "clr2");
    chk("clr_dout", {dout, intl}, {16'h1F00, 1'b0});
    step("clr_intl");
    chk("clr_intl_hi", {dout, intl}, {16'h1F00, 1'b1});
    repeat (3) step("no_retrig");
    chk("no_retrig_end", {dout, intl}, {16'h1F00, 1'b1});

    // Disabled edge discarded.
    wrcyc(16'h0000, "dis_all");
    src = 5'b11110;
    step("src0_low");
    src = 5'b11111;
    step("src0_dis_edge");
    wrcyc(16'h0001, "en0");
    repeat (2) step("dis_discard");
    chk("discard", {dout, intl}, {16'h0100, 1'b1});

    // Edge and clear in the same cycle: set wins.
    src = 5'b11110;
    step("src0_low2");
    src = 5'b11111;
    wrcyc(16'h0101, "set_win");
    chk("set_wins", {dout, intl}, {16'h0101, 1'b1});
    step("set_win_intl");
    chk("set_wins_intl", {dout, intl}, {16'h0101, 1'b0});
    wrcyc(16'h0101, "clr0");
    step("clr0_intl");
    chk("clr0_done", {dout, intl}, {16'h0100, 1'b1});

    // Disabling write coinciding with edge latches; re-enable asserts.
    src = 5'b11110;
    step("src0_low3");
    src = 5'b11111;
    wrcyc(16'h0000, "dis_edge");
    chk("dis_edge_lat", {dout, intl}, {16'h0001, 1'b1});
    step("dis_edge_quiet");
    chk("dis_pend_quiet", {dout, intl}, {16'h0001, 1'b1});
    wrcyc(16'h0001, "reen");
    step("reen_intl");
    chk("reen_low", {dout, intl}, {16'h0101, 1'b0});
    wrcyc(16'hF0E1, "clr_junk");
    step("clr_junk_intl");
    chk("junk_ignored", {dout, intl}, {16'h0101, 1'b0});
    wrcyc(16'h0101, "clr0b");
    step("clr0b_intl");

    // Two sources, then async reset mid-request.
    wrcyc(16'h001F, "en_all2");
    src = 5'b10101;
    step("src13_low");
    src = 5'b11111;
    step("src13_edge");
    step("src13_intl");
    chk("two_src", {dout, intl}, {16'h1F0A, 1'b0});
    #2;
    resetl = 1'b0;
    m_reset();
    #1;
    chk("async_rst", {dout, intl}, {16'h0000, 1'b1});
    @(posedge sys_clk);
    #1;
    resetl = 1'b1;
    wrcyc(16'h001F, "post_rst_en");
    repeat (3) step("post_rst_hi");
    chk("post_rst_none", {dout, intl}, {16'h1F00, 1'b1});
    src = 5'b11101;
    step("post_src1_low");
    src = 5'b11111;
    step("post_src1_edge");
    step("post_src1_intl");
    chk("post_rst_edge", {dout, intl}, {16'h1F02, 1'b0});

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      src = N'($urandom);
      wr  = ($urandom_range(0, 3) == 0);
      din = 16'($urandom);
      step("rand");
    end
    wr  = 1'b0;
    din = '0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
